// File: rtl/mlp_pkg.sv
// Shared constants and FSM encoding for the two-layer MLP engine.
package mlp_pkg;

  localparam int N_IN   = 196;
  localparam int N_HID  = 32;
  localparam int N_OUT  = 10;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int SHIFT  = 7;

  // Weight ROM layout: hidden rows (weights then bias), then output rows.
  localparam int HID_ROW  = N_IN + 1;
  localparam int OUT_ROW  = N_HID + 1;
  localparam int OUT_BASE = N_HID * HID_ROW;

  typedef enum logic [2:0] {
    IDLE,
    HID_MAC,
    HID_DRAIN,
    HID_WB,
    OUT_MAC,
    OUT_DRAIN,
    OUT_CMP,
    DONE
  } state_t;

endpackage

// File: rtl/mlp_if.sv
// Start/done handshake plus the input-buffer and weight-ROM read ports of the MLP engine.
interface mlp_if #(
    parameter int DATA_W    = 8,
    parameter int IN_ADDR_W = 8,
    parameter int W_ADDR_W  = 13
);
  // mlp_go is a level held by the controller until it sees the one-cycle mlp_done;
  // digit is valid from mlp_done until the next run. Each rd_en strobe returns
  // its data on the matching *_data bus exactly one cycle later.
  logic                        mlp_go;
  logic                        mlp_done;
  logic [3:0]                  digit;
  logic                        in_rd_en;
  logic [IN_ADDR_W-1:0]        in_addr;
  logic signed [DATA_W-1:0]    in_data;
  logic                        w_rd_en;
  logic [W_ADDR_W-1:0]         w_addr;
  logic signed [DATA_W-1:0]    w_data;

  modport master (
    output mlp_go, in_data, w_data,
    input  mlp_done, digit, in_rd_en, in_addr, w_rd_en, w_addr
  );

  modport slave (
    input  mlp_go, in_data, w_data,
    output mlp_done, digit, in_rd_en, in_addr, w_rd_en, w_addr
  );

endinterface

// File: rtl/mlp_mac.sv
// Signed multiply-accumulate; bias_en adds the sign-extended b operand on its own.
module mlp_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     mul_en,
    input  logic                     bias_en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);
    import mlp_pkg::*;

    logic signed [2*DATA_W-1:0] prod;

    assign prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc <= '0;
        end else if (mul_en) begin
            acc <= acc + ACC_W'(prod);
        end else if (bias_en) begin
            acc <= acc + ACC_W'(b);
        end
    end

endmodule

// File: rtl/mlp_engine.sv
// Two-layer MLP responder: hidden ReLU/requantize layer, output scores, argmax digit.
module mlp_engine #(
    parameter int N_IN      = mlp_pkg::N_IN,
    parameter int N_HID     = mlp_pkg::N_HID,
    parameter int N_OUT     = mlp_pkg::N_OUT,
    parameter int DATA_W    = mlp_pkg::DATA_W,
    parameter int ACC_W     = mlp_pkg::ACC_W,
    parameter int SHIFT     = mlp_pkg::SHIFT,
    parameter int IN_ADDR_W = 8,
    parameter int W_ADDR_W  = 13
) (
    input  logic            clk,
    input  logic            reset,
    mlp_if.slave            bus,
    output mlp_pkg::state_t dbg_state
);
    import mlp_pkg::*;

    localparam int K_MAX = (N_IN > N_HID) ? N_IN : N_HID;
    localparam int K_W   = $clog2(K_MAX + 2);
    localparam int N_MAX = (N_HID > N_OUT) ? N_HID : N_OUT;
    localparam int N_W   = $clog2(N_MAX + 1);
    localparam int HI_W  = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam logic signed [ACC_W-1:0] HID_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);

    state_t                   state;
    logic [K_W-1:0]           k;
    logic [N_W-1:0]           n;
    logic                     done_q;
    logic [3:0]               digit_q;
    logic                     in_rd_q;
    logic [IN_ADDR_W-1:0]     in_addr_q;
    logic                     w_rd_q;
    logic [W_ADDR_W-1:0]      w_addr_q;
    logic                     bias_word;
    logic                     mul_q;
    logic                     bias_q;
    logic                     armed;
    logic signed [DATA_W-1:0] hid_q;
    logic signed [ACC_W-1:0]  best;
    logic [N_W-1:0]           best_idx;
    logic signed [DATA_W-1:0] hidden [N_HID];

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [DATA_W-1:0] hid_new;
    logic signed [DATA_W-1:0] mac_a;
    logic                     take;

    assign shifted = acc >>> SHIFT;

    always_comb begin
        hid_new = shifted[DATA_W-1:0];
        if (shifted[ACC_W-1]) begin
            hid_new = '0;
        end else if (shifted > HID_MAX) begin
            hid_new = HID_MAX[DATA_W-1:0];
        end
    end

    // Strict '>' so a tie keeps the lower class index.
    assign take  = (n == '0) || (acc > best);
    assign mac_a = (state == OUT_MAC || state == OUT_DRAIN) ? hid_q : bus.in_data;

    mlp_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == HID_WB || state == OUT_CMP),
        .mul_en  (mul_q),
        .bias_en (bias_q),
        .a       (mac_a),
        .b       (bus.w_data),
        .acc     (acc)
    );

    assign bus.mlp_done = done_q;
    assign bus.digit    = digit_q;
    assign bus.in_rd_en = in_rd_q;
    assign bus.in_addr  = in_addr_q;
    assign bus.w_rd_en  = w_rd_q;
    assign bus.w_addr   = w_addr_q;
    assign dbg_state    = state;

    // The weight ROM is walked strictly in order, so w_addr simply increments per strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k         <= '0;
            n         <= '0;
            done_q    <= 1'b0;
            digit_q   <= '0;
            in_rd_q   <= 1'b0;
            in_addr_q <= '0;
            w_rd_q    <= 1'b0;
            w_addr_q  <= '0;
            bias_word <= 1'b0;
            mul_q     <= 1'b0;
            bias_q    <= 1'b0;
            armed     <= 1'b1;
            hid_q     <= '0;
            best      <= '0;
            best_idx  <= '0;
            for (int i = 0; i < N_HID; i++) hidden[i] <= '0;
        end else begin
            mul_q  <= w_rd_q & ~bias_word;
            bias_q <= w_rd_q & bias_word;
            done_q <= 1'b0;
            if (!bus.mlp_go) armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.mlp_go && armed) begin
                        armed     <= 1'b0;
                        state     <= HID_MAC;
                        k         <= '0;
                        n         <= '0;
                        w_rd_q    <= 1'b1;
                        w_addr_q  <= '0;
                        in_rd_q   <= 1'b1;
                        in_addr_q <= '0;
                        bias_word <= 1'b0;
                    end
                end
                HID_MAC: begin
                    if (k == K_W'(N_IN)) begin
                        state     <= HID_DRAIN;
                        w_rd_q    <= 1'b0;
                        in_rd_q   <= 1'b0;
                        bias_word <= 1'b0;
                    end else begin
                        k         <= k + K_W'(1);
                        w_addr_q  <= w_addr_q + W_ADDR_W'(1);
                        in_rd_q   <= (k + K_W'(1) != K_W'(N_IN));
                        bias_word <= (k + K_W'(1) == K_W'(N_IN));
                        if (k + K_W'(1) != K_W'(N_IN)) in_addr_q <= IN_ADDR_W'(k + K_W'(1));
                    end
                end
                HID_DRAIN: state <= HID_WB;
                HID_WB: begin
                    hidden[n[HI_W-1:0]] <= hid_new;
                    k         <= '0;
                    w_rd_q    <= 1'b1;
                    w_addr_q  <= w_addr_q + W_ADDR_W'(1);
                    bias_word <= 1'b0;
                    if (n == N_W'(N_HID - 1)) begin
                        state <= OUT_MAC;
                        n     <= '0;
                    end else begin
                        state     <= HID_MAC;
                        n         <= n + N_W'(1);
                        in_rd_q   <= 1'b1;
                        in_addr_q <= '0;
                    end
                end
                OUT_MAC: begin
                    hid_q <= (k < K_W'(N_HID)) ? hidden[k[HI_W-1:0]] : '0;
                    if (k == K_W'(N_HID)) begin
                        state     <= OUT_DRAIN;
                        w_rd_q    <= 1'b0;
                        bias_word <= 1'b0;
                    end else begin
                        k         <= k + K_W'(1);
                        w_addr_q  <= w_addr_q + W_ADDR_W'(1);
                        bias_word <= (k + K_W'(1) == K_W'(N_HID));
                    end
                end
                OUT_DRAIN: state <= OUT_CMP;
                OUT_CMP: begin
                    if (take) begin
                        best     <= acc;
                        best_idx <= n;
                    end
                    if (n == N_W'(N_OUT - 1)) begin
                        state   <= DONE;
                        done_q  <= 1'b1;
                        digit_q <= take ? 4'(n) : 4'(best_idx);
                    end else begin
                        state     <= OUT_MAC;
                        n         <= n + N_W'(1);
                        k         <= '0;
                        w_rd_q    <= 1'b1;
                        w_addr_q  <= w_addr_q + W_ADDR_W'(1);
                        bias_word <= 1'b0;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_engine.sv
// Directed bench for mlp_engine on a 4-2-3 network with hand-computed digits and address stream.
module tb_mlp_engine;

  localparam int T_IN     = 4;
  localparam int T_HID    = 2;
  localparam int T_OUT    = 3;
  localparam int HID_ROW  = T_IN + 1;
  localparam int OUT_ROW  = T_HID + 1;
  localparam int OUT_BASE = T_HID * HID_ROW;
  localparam int ROM_N    = OUT_BASE + T_OUT * OUT_ROW;
  localparam int HID_CYC  = T_HID * (T_IN + 3);
  localparam int LAT      = HID_CYC + T_OUT * (T_HID + 3);

  logic clk = 1'b0;
  logic reset;
  mlp_pkg::state_t dbg_state;

  mlp_if #(.DATA_W(8), .IN_ADDR_W(8), .W_ADDR_W(13)) bus ();

  mlp_engine #(
    .N_IN(T_IN), .N_HID(T_HID), .N_OUT(T_OUT), .DATA_W(8), .ACC_W(24),
    .SHIFT(2), .IN_ADDR_W(8), .W_ADDR_W(13)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Synchronous-read memory models, one cycle of latency
  logic signed [7:0] pix  [T_IN];
  logic signed [7:0] wrom [ROM_N];

  always @(posedge clk) begin
    if (bus.in_rd_en) bus.in_data <= pix[bus.in_addr];
    if (bus.w_rd_en)  bus.w_data  <= wrom[bus.w_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bus_obs();
    logic [12:0] wa;
    logic [7:0]  ia;
    wa = bus.w_rd_en  ? bus.w_addr  : 13'd0;
    ia = bus.in_rd_en ? bus.in_addr : 8'd0;
    return {8'd0, bus.mlp_done, bus.w_rd_en, wa, bus.in_rd_en, ia};
  endfunction

  // Expected strobes/addresses in the cycle after edge t (edge 0 samples go)
  function automatic logic [31:0] bus_exp(input int t);
    logic        wr, ir, dn;
    logic [12:0] wa;
    logic [7:0]  ia;
    int h, j, p, q;
    wr = 1'b0; ir = 1'b0; wa = '0; ia = '0;
    dn = (t == LAT);
    if (t < HID_CYC) begin
      h = t / (T_IN + 3);
      p = t % (T_IN + 3);
      if (p <= T_IN) begin
        wr = 1'b1;
        wa = 13'(h * HID_ROW + p);
        if (p < T_IN) begin
          ir = 1'b1;
          ia = 8'(p);
        end
      end
    end else if (t < LAT) begin
      q = t - HID_CYC;
      j = q / (T_HID + 3);
      p = q % (T_HID + 3);
      if (p <= T_HID) begin
        wr = 1'b1;
        wa = 13'(OUT_BASE + j * OUT_ROW + p);
      end
    end
    return {8'd0, dn, wr, wa, ir, ia};
  endfunction

  // Driver tasks
  task automatic set_pix(input int p0, input int p1, input int p2, input int p3);
    pix[0] = 8'(p0); pix[1] = 8'(p1); pix[2] = 8'(p2); pix[3] = 8'(p3);
  endtask

  task automatic set_hid(input int h, input int w0, input int w1, input int w2, input int w3,
                         input int b);
    wrom[h*HID_ROW+0] = 8'(w0);
    wrom[h*HID_ROW+1] = 8'(w1);
    wrom[h*HID_ROW+2] = 8'(w2);
    wrom[h*HID_ROW+3] = 8'(w3);
    wrom[h*HID_ROW+4] = 8'(b);
  endtask

  task automatic set_out(input int j, input int w0, input int w1, input int b);
    wrom[OUT_BASE+j*OUT_ROW+0] = 8'(w0);
    wrom[OUT_BASE+j*OUT_ROW+1] = 8'(w1);
    wrom[OUT_BASE+j*OUT_ROW+2] = 8'(b);
  endtask

  task automatic drop_go();
    @(negedge clk);
    bus.mlp_go = 1'b0;
  endtask

  // Raise go, check every cycle's strobes through the done pulse, then the digit
  task automatic do_run(input string tag, input int exp_digit, input int drop_at);
    @(negedge clk);
    bus.mlp_go = 1'b1;
    @(posedge clk);
    for (int t = 0; t <= LAT; t++) begin
      #1;
      check_eq($sformatf("%s_bus_t%0d", tag, t), bus_obs(), bus_exp(t));
      if (t == drop_at) bus.mlp_go = 1'b0;
      if (t < LAT) @(posedge clk);
    end
    check_eq({tag, "_digit"}, 32'(bus.digit), 32'(exp_digit));
    check_eq({tag, "_state_done"}, 32'(dbg_state), 32'(mlp_pkg::DONE));
    @(posedge clk);
    #1;
    check_eq({tag, "_done_width"}, 32'(bus.mlp_done), 32'd0);
    check_eq({tag, "_digit_hold"}, 32'(bus.digit), 32'(exp_digit));
    check_eq({tag, "_state_idle"}, 32'(dbg_state), 32'(mlp_pkg::IDLE));
  endtask

  initial begin
    reset = 1'b1;
    bus.mlp_go = 1'b0;
    for (int i = 0; i < ROM_N; i++) wrom[i] = '0;
    set_pix(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_bus", bus_obs(), 32'd0);
    check_eq("rst_addr", {19'd0, bus.w_addr}, 32'd0);
    check_eq("rst_digit", 32'(bus.digit), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(mlp_pkg::IDLE));
    @(negedge clk);
    reset = 1'b0;

    // hidden=[1,1]; scores 2,4,4 -> tie keeps index 1
    set_pix(1, 1, 1, 1);
    set_hid(0, 1, 1, 1, 1, 0);
    set_hid(1, 1, 1, 1, 1, 0);
    set_out(0, 1, 1, 0);
    set_out(1, 2, 2, 0);
    set_out(2, 2, 2, 0);
    do_run("tie", 1, -1);
    drop_go();

    // ReLU clamps hidden to 0, so only biases 5,-3,7 remain; go falls mid-run
    set_hid(0, -1, -1, -1, -1, 0);
    set_hid(1, -1, -1, -1, -1, 0);
    set_out(0, -9, -9, 5);
    set_out(1, 0, 0, -3);
    set_out(2, 0, 0, 7);
    do_run("relu", 2, 5);

    // hidden acc 64516 >>> 2 = 16129 saturates to 127: scores 127,126,-254
    set_pix(127, 127, 127, 127);
    set_hid(0, 127, 127, 127, 127, 0);
    set_hid(1, 127, 127, 127, 127, 0);
    set_out(0, 1, 0, 0);
    set_out(1, 0, 0, 126);
    set_out(2, -1, -1, 0);
    do_run("sat", 0, -1);
    drop_go();

    // Mixed signs: hidden=[3,8], scores 11,23,24
    set_pix(3, -2, 5, 1);
    set_hid(0, 2, 4, -1, 7, 12);
    set_hid(1, -3, 1, 2, -4, 40);
    set_out(0, 1, 1, 0);
    set_out(1, -2, 3, 5);
    set_out(2, 5, 0, 9);
    do_run("mixed", 2, -1);

    // go held high after done must not restart
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("hold_c%0d", c), bus_obs(), 32'd0);
    end
    drop_go();
    do_run("rearm", 2, -1);
    drop_go();

    // Reset ten cycles into a run, then a clean run
    set_pix(1, 1, 1, 1);
    set_hid(0, -1, -1, -1, -1, 0);
    set_hid(1, -1, -1, -1, -1, 0);
    set_out(0, -9, -9, 5);
    set_out(1, 0, 0, -3);
    set_out(2, 0, 0, 7);
    @(negedge clk);
    bus.mlp_go = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.mlp_go = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_bus", bus_obs(), 32'd0);
    check_eq("midrst_digit", 32'(bus.digit), 32'd0);
    check_eq("midrst_state", 32'(dbg_state), 32'(mlp_pkg::IDLE));
    @(negedge clk);
    reset = 1'b0;
    do_run("after_rst", 2, -1);
    drop_go();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
